// File: rtl/intr_arb.sv
// Priority interrupt arbiter: picks one eligible source by BR level, then by round-robin.
// It presents that source to the CPU, completes the acknowledge and pulses a one-hot grant.
module intr_arb #(
    parameter int N       = 4,
    parameter int HOLDOFF = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   irq,
    input  logic [8*N-1:0] irq_vec,
    input  logic [3*N-1:0] irq_lvl,
    input  logic [2:0]     cpu_pri,
    input  logic           int_ack,
    output logic           interrupt,
    output logic [7:0]     vector,
    output logic [N-1:0]   grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] last_q, last_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          int_q, int_d;
    logic [7:0]    vector_q, vector_d;
    logic [N-1:0]  grant_q, grant_d;

    logic [N-1:0]  elig;
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic [2:0]    arb_lvl;
    logic [7:0]    arb_vec;
    int            scan_idx;

    // Per-source eligibility: requesting and strictly above the processor priority.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = irq[i] && (irq_lvl[3*i +: 3] > cpu_pri);
        end
    end

    // Scan starting just after the last grant; strict '>' keeps the first source of a tied level.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_lvl   = 3'd0;
        arb_vec   = 8'd0;
        scan_idx  = 0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = (int'(last_q) + k) % N;
            if (elig[scan_idx] && (!arb_found || (irq_lvl[3*scan_idx +: 3] > arb_lvl))) begin
                arb_found = 1'b1;
                arb_idx   = IW'(scan_idx);
                arb_lvl   = irq_lvl[3*scan_idx +: 3];
                arb_vec   = irq_vec[8*scan_idx +: 8];
            end else begin
                arb_found = arb_found;
            end
        end
    end

    // Next-state and registered-output logic for the request/acknowledge handshake.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        int_d    = int_q;
        vector_d = vector_q;
        grant_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    win_d    = arb_idx;
                    vector_d = arb_vec;
                    int_d    = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Acknowledge outranks a same-cycle withdraw; the latched winner is never re-arbitrated.
                if (int_ack) begin
                    grant_d  = {{(N-1){1'b0}}, 1'b1} << win_q;
                    int_d    = 1'b0;
                    vector_d = 8'd0;
                    state_d  = ST_GRANT;
                end else if (!elig[win_q]) begin
                    int_d    = 1'b0;
                    vector_d = 8'd0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_REQ;
                end
            end
            ST_GRANT: begin
                last_d  = win_q;
                cnt_d   = 3'(HOLDOFF);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                int_d    = 1'b0;
                vector_d = 8'd0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            last_q   <= IW'(N - 1);
            cnt_q    <= 3'd0;
            int_q    <= 1'b0;
            vector_q <= 8'd0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            int_q    <= int_d;
            vector_q <= vector_d;
            grant_q  <= grant_d;
        end
    end

    assign interrupt = int_q;
    assign vector    = vector_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_intr_arb.sv
// Self-checking bench for intr_arb: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_intr_arb;

    localparam int N       = 4;
    localparam int HOLDOFF = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   irq;
    logic [8*N-1:0] irq_vec;
    logic [3*N-1:0] irq_lvl;
    logic [2:0]     cpu_pri;
    logic           int_ack;
    logic           interrupt;
    logic [7:0]     vector;
    logic [N-1:0]   grant;

    int errors = 0;
    int checks = 0;

    // Model state: pending request, grant-cycle flag, remaining hold cycles, round-robin pointer.
    bit         m_pend     = 1'b0;
    bit         m_granting = 1'b0;
    int         m_src      = 0;
    int         m_last     = N - 1;
    int         m_hold     = 0;
    logic       exp_int    = 1'b0;
    logic [7:0] exp_vec    = 8'd0;
    logic [N-1:0] exp_grant = '0;

    logic [N-1:0] g;
    logic [N-1:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    intr_arb #(.N(N), .HOLDOFF(HOLDOFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .irq_vec   (irq_vec),
        .irq_lvl   (irq_lvl),
        .cpu_pri   (cpu_pri),
        .int_ack   (int_ack),
        .interrupt (interrupt),
        .vector    (vector),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    function automatic int lvl_of(int i);
        return int'(irq_lvl[3*i +: 3]);
    endfunction

    function automatic bit elig(int i);
        return irq[i] && (lvl_of(i) > int'(cpu_pri));
    endfunction

    // Highest level first; within a level, the source closest after m_last in circular order.
    function automatic int pick();
        int best;
        int bestd;
        int d;
        for (int l = 7; l >= 0; l--) begin
            best  = -1;
            bestd = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_last - 1 + 2 * N) % N;
                if (elig(i) && lvl_of(i) == l && d < bestd) begin
                    best  = i;
                    bestd = d;
                end
            end
            if (best >= 0) return best;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        exp_grant = '0;
        if (reset) begin
            m_pend = 1'b0; m_granting = 1'b0; m_hold = 0; m_last = N - 1;
            exp_int = 1'b0; exp_vec = 8'd0;
        end else if (m_granting) begin
            m_granting = 1'b0; m_last = m_src; m_hold = HOLDOFF;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_pend) begin
            if (int_ack) begin
                exp_grant[m_src] = 1'b1;
                m_pend = 1'b0; m_granting = 1'b1;
                exp_int = 1'b0; exp_vec = 8'd0;
            end else if (!elig(m_src)) begin
                m_pend = 1'b0; exp_int = 1'b0; exp_vec = 8'd0;
            end
        end else begin
            w = pick();
            if (w >= 0) begin
                m_pend = 1'b1; m_src = w;
                exp_int = 1'b1; exp_vec = irq_vec[8*w +: 8];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("interrupt", 32'(interrupt), 32'(exp_int));
        check("vector", 32'(vector), 32'(exp_vec));
        check("grant", 32'(grant), 32'(exp_grant));
    endtask

    task automatic wait_int(input int max);
        int n = 0;
        while (!interrupt && n < max) begin
            cycle();
            n++;
        end
        check("wait_int_timeout", 32'(interrupt), 32'd1);
    endtask

    task automatic ack(output logic [N-1:0] gnt);
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        gnt = grant;
    endtask

    task automatic set_src(input int i, input logic on, input logic [2:0] lvl, input logic [7:0] vec);
        irq[i]           = on;
        irq_lvl[3*i +: 3] = lvl;
        irq_vec[8*i +: 8] = vec;
    endtask

    initial begin
        reset = 1'b1; irq = '0; irq_vec = '0; irq_lvl = '0; cpu_pri = 3'd0; int_ack = 1'b0;
        repeat (2) cycle();
        check("reset_int", 32'(interrupt), 32'd0);
        reset = 1'b0;

        // Single source, ack, and holdoff spacing before the re-request
        set_src(1, 1'b1, 3'd4, 8'o64);
        cycle();
        check("single_int", 32'(interrupt), 32'd1);
        check("single_vec", 32'(vector), 32'(8'o64));
        ack(g);
        check("single_grant", 32'(g), 32'(4'b0010));
        check("single_int_drop", 32'(interrupt), 32'd0);
        repeat (HOLDOFF + 1) cycle();
        check("holdoff_gap", 32'(interrupt), 32'd0);
        cycle();
        check("rereq", 32'(interrupt), 32'd1);
        irq[1] = 1'b0;
        cycle();

        // Level priority
        set_src(0, 1'b1, 3'd4, 8'o60);
        set_src(2, 1'b1, 3'd6, 8'o100);
        cycle();
        check("lvl_first_vec", 32'(vector), 32'(8'o100));
        ack(g);
        check("lvl_first_grant", 32'(g), 32'(4'b0100));
        irq[2] = 1'b0;
        wait_int(10);
        check("lvl_second_vec", 32'(vector), 32'(8'o60));
        ack(g);
        check("lvl_second_grant", 32'(g), 32'(4'b0001));
        irq = '0;
        repeat (HOLDOFF + 1) cycle();

        // Round-robin among equal levels from a fresh pointer
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_src(0, 1'b1, 3'd4, 8'o60);
        set_src(1, 1'b1, 3'd4, 8'o64);
        set_src(2, 1'b0, 3'd4, 8'o100);
        set_src(3, 1'b1, 3'd4, 8'o70);
        for (int k = 0; k < 4; k++) begin
            wait_int(10);
            ack(g);
            check("rr_grant", 32'(g), 32'(rr_exp[k]));
        end
        irq = '0;
        repeat (HOLDOFF + 1) cycle();

        // Masking by processor priority
        cpu_pri = 3'd4;
        set_src(0, 1'b1, 3'd4, 8'o60);
        repeat (3) cycle();
        check("mask_hold", 32'(interrupt), 32'd0);
        cpu_pri = 3'd3;
        cycle();
        check("unmask", 32'(interrupt), 32'd1);
        cpu_pri = 3'd4;
        cycle();
        check("remask", 32'(interrupt), 32'd0);
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        check("remask_ack_ignored", 32'(grant), 32'd0);
        cpu_pri = 3'd0;

        // Withdraw vs. ack race
        wait_int(10);
        irq[0] = 1'b0;
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        check("race_grant", 32'(grant), 32'(4'b0001));
        check("race_int", 32'(interrupt), 32'd0);
        repeat (HOLDOFF + 1) cycle();
        irq[0] = 1'b1;
        wait_int(10);
        irq[0] = 1'b0;
        cycle();
        check("withdraw_int", 32'(interrupt), 32'd0);
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        check("late_ack", 32'(grant), 32'd0);

        // Reset mid-request restores the pointer so source 0 wins the tie
        set_src(0, 1'b1, 3'd5, 8'o60);
        set_src(2, 1'b1, 3'd5, 8'o100);
        wait_int(10);
        check("pre_reset_vec", 32'(vector), 32'(8'o100));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_int", 32'(interrupt), 32'd0);
        check("rst_vec", 32'(vector), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        cycle();
        check("post_reset_vec", 32'(vector), 32'(8'o60));
        ack(g);
        check("post_reset_grant", 32'(g), 32'(4'b0001));
        irq = '0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)  irq = N'($urandom);
            if ($urandom_range(0, 15) == 0) irq_lvl = (3*N)'($urandom);
            if ($urandom_range(0, 7) == 0)  irq_vec = (8*N)'($urandom);
            if ($urandom_range(0, 15) == 0) cpu_pri = 3'($urandom_range(0, 5));
            int_ack = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0; int_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
